// File: rtl/sitcpxg_rx_buffer.sv
// sitcpxg_rx_buffer: byte-enabled 64-bit SiTCP receive writes re-laned into a little-endian valid/ready stream.
module sitcpxg_rx_buffer #(
  parameter int LANE_BYTES = 8,
  parameter int ADDR_BITS  = 13
) (
  input  logic                    XGMII_CLOCK,
  input  logic                    RSTn,
  input  logic [15:0]             RX_WADR,
  input  logic [7:0]              RX_WENB,
  input  logic [63:0]             RX_WDAT,
  input  logic                    RX_CLR_ENB,
  output logic                    RX_CLR_REQ,
  output logic [15:0]             RX_RADR,
  output logic [15:0]             RX_SIZE,
  input  logic                    USER_CLR,
  output logic [8*LANE_BYTES-1:0] OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [ADDR_BITS:0]      FILL,
  output logic                    OVERFLOW
);
  localparam int W  = 8 * LANE_BYTES;
  localparam int FW = ADDR_BITS + 1;
  localparam int CW = ADDR_BITS + 2;
  localparam int WA = ADDR_BITS - 3;
  localparam int RW = ADDR_BITS;
  localparam logic [ADDR_BITS:0] LB = FW'(LANE_BYTES);
  localparam logic [ADDR_BITS+1:0] CAP = CW'(1) << ADDR_BITS;
  typedef enum logic [1:0] {RUN, CLR_PEND, CLR_EXEC} state_t;
  state_t state;
  logic rst_q;
  logic [63:0] ram_q, sh;
  logic [2:0] rd_off;
  logic rd_v;
  logic [ADDR_BITS:0] wr_cnt, rd_iss, avail;
  logic [ADDR_BITS-1:0] radr;
  logic [W-1:0] q1, din;
  logic [1:0] qn, qc;
  logic [3:0] pc;
  logic pop, push, issue, exec, unused;
  always_ff @(posedge XGMII_CLOCK or negedge RSTn)
    if (!RSTn) rst_q <= 1'b0;
    else rst_q <= 1'b1;
  // One byte-wide RAM per write-enable lane; byte 7 of the bus is the lowest address.
  for (genvar i = 0; i < 8; i++) begin : g_ram
    logic [7:0] m [2**WA];
    logic [7:0] q;
    always_ff @(posedge XGMII_CLOCK) begin
      if (!exec && RX_WENB[i]) m[RX_WADR[ADDR_BITS-1:3]] <= RX_WDAT[8*i +: 8];
      q <= m[rd_iss[ADDR_BITS-1:3]];
    end
    assign ram_q[8*i +: 8] = q;
  end
  assign RX_SIZE   = 16'((1 << ADDR_BITS) - 16);
  assign RX_RADR   = 16'(radr);
  assign OUT_VALID = qn != 2'd0;
  assign exec      = state == CLR_EXEC;
  assign pc        = exec ? 4'd0 : 4'($countones(RX_WENB));
  assign avail     = wr_cnt - rd_iss;
  assign pop       = OUT_VALID && OUT_READY;
  assign push      = rd_v;
  assign qc        = qn - 2'(pop);
  // Room counts the beat still in the RAM pipeline so the 2-entry queue never overruns.
  assign issue     = !exec && avail >= LB && qc + 2'(rd_v) < 2'd2;
  assign sh        = ram_q << {rd_off, 3'b000};
  assign unused    = ^{RX_WADR, sh};
  always_comb begin
    din = '0;
    for (int j = 0; j < LANE_BYTES; j++) din[8*j +: 8] = sh[63-8*j -: 8];
  end
  always_ff @(posedge XGMII_CLOCK or negedge rst_q)
    if (!rst_q) begin
      state      <= RUN;
      RX_CLR_REQ <= 1'b0;
      wr_cnt     <= '0;
      rd_iss     <= '0;
      rd_v       <= 1'b0;
      rd_off     <= '0;
      radr       <= '0;
      FILL       <= '0;
      OVERFLOW   <= 1'b0;
      OUT_DATA   <= '0;
      q1         <= '0;
      qn         <= '0;
    end else if (exec) begin
      state      <= RUN;
      RX_CLR_REQ <= 1'b0;
      wr_cnt     <= '0;
      rd_iss     <= '0;
      rd_v       <= 1'b0;
      rd_off     <= '0;
      radr       <= '0;
      FILL       <= '0;
      OVERFLOW   <= 1'b0;
      OUT_DATA   <= '0;
      q1         <= '0;
      qn         <= '0;
    end else begin
      state      <= (state == RUN && USER_CLR) ? CLR_PEND :
                    (state == CLR_PEND && RX_CLR_ENB) ? CLR_EXEC : state;
      RX_CLR_REQ <= state == CLR_PEND && RX_CLR_ENB;
      wr_cnt     <= wr_cnt + FW'(pc);
      rd_iss     <= issue ? rd_iss + LB : rd_iss;
      rd_v       <= issue;
      rd_off     <= rd_iss[2:0];
      radr       <= pop ? radr + RW'(LANE_BYTES) : radr;
      FILL       <= FILL + FW'(pc) - (pop ? LB : '0);
      if ({1'b0, FILL} + CW'(pc) > CAP) OVERFLOW <= 1'b1;
      OUT_DATA   <= (push && qc == 2'd0) ? din : pop ? q1 : OUT_DATA;
      q1         <= (push && qc == 2'd1) ? din : q1;
      qn         <= qc + 2'(push);
    end
endmodule

// File: tb/tb_sitcpxg_rx_buffer.sv
// tb_sitcpxg_rx_buffer: directed checks of lane widths 8/1/4, backpressure, overflow, clear handshake and reset.
module tb_sitcpxg_rx_buffer;
  localparam logic [63:0] A = 64'h0011223344556677;
  localparam logic [63:0] B = 64'h8899AABBCCDDEEFF;
  logic clk = 1'b0, rstn = 1'b1;
  logic [15:0] rx_wadr = '0;
  logic [7:0] rx_wenb = '0;
  logic [63:0] rx_wdat = '0;
  logic rx_clr_enb = 1'b0, user_clr = 1'b0, out_ready = 1'b1;
  int n_vec = 0, n_err = 0;
  logic clr_req8, clr_req1, clr_req4, valid8, valid1, valid4, ovf8, ovf1, ovf4;
  logic [15:0] radr8, radr1, radr4, size8, size1, size4;
  logic [63:0] data8;
  logic [7:0] data1;
  logic [31:0] data4;
  logic [12:0] fill8;
  logic [13:0] fill1, fill4;
  sitcpxg_rx_buffer #(.LANE_BYTES(8), .ADDR_BITS(12)) d8 (
    .XGMII_CLOCK(clk), .RSTn(rstn), .RX_WADR(rx_wadr), .RX_WENB(rx_wenb), .RX_WDAT(rx_wdat),
    .RX_CLR_ENB(rx_clr_enb), .RX_CLR_REQ(clr_req8), .RX_RADR(radr8), .RX_SIZE(size8),
    .USER_CLR(user_clr), .OUT_DATA(data8), .OUT_VALID(valid8), .OUT_READY(out_ready),
    .FILL(fill8), .OVERFLOW(ovf8));
  sitcpxg_rx_buffer #(.LANE_BYTES(1), .ADDR_BITS(13)) d1 (
    .XGMII_CLOCK(clk), .RSTn(rstn), .RX_WADR(rx_wadr), .RX_WENB(rx_wenb), .RX_WDAT(rx_wdat),
    .RX_CLR_ENB(rx_clr_enb), .RX_CLR_REQ(clr_req1), .RX_RADR(radr1), .RX_SIZE(size1),
    .USER_CLR(user_clr), .OUT_DATA(data1), .OUT_VALID(valid1), .OUT_READY(out_ready),
    .FILL(fill1), .OVERFLOW(ovf1));
  sitcpxg_rx_buffer #(.LANE_BYTES(4), .ADDR_BITS(13)) d4 (
    .XGMII_CLOCK(clk), .RSTn(rstn), .RX_WADR(rx_wadr), .RX_WENB(rx_wenb), .RX_WDAT(rx_wdat),
    .RX_CLR_ENB(rx_clr_enb), .RX_CLR_REQ(clr_req4), .RX_RADR(radr4), .RX_SIZE(size4),
    .USER_CLR(user_clr), .OUT_DATA(data4), .OUT_VALID(valid4), .OUT_READY(out_ready),
    .FILL(fill4), .OVERFLOW(ovf4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] e, input logic [63:0] d);
    rx_wadr = a;
    rx_wenb = e;
    rx_wdat = d;
    step;
    rx_wenb = '0;
  endtask
  task automatic reset;
    rstn = 1'b0;
    repeat (3) step;
    rstn = 1'b1;
    repeat (3) step;
  endtask
  initial begin
    step;
    reset;
    chk("rst_valid", valid8, 0);
    chk("rst_data", data8, 0);
    chk("rst_fill", fill8, 0);
    chk("rst_radr", radr8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_clrreq", clr_req8, 0);
    chk("size12", size8, 16'h0FF0);
    chk("size13", size1, 16'h1FF0);
    // one full word: lane 8 latency, lane 1 streaming, lane 4 pair
    wr(16'h0000, 8'hFF, A);
    chk("fill8_wr", fill8, 8);
    chk("fill1_wr", fill1, 8);
    step;
    chk("lat8_low", valid8, 0);
    step;
    chk("lat8_rise", valid8, 1);
    chk("beat8", data8, 64'h7766554433221100);
    chk("beat4_0", data4, 32'h33221100);
    for (int k = 0; k < 8; k++) begin
      chk("beat1_valid", valid1, 1);
      chk("beat1_data", data1, 8'(k * 17));
      chk("beat1_radr", radr1, k);
      if (k == 1) chk("beat4_1", data4, 32'h77665544);
      step;
    end
    chk("radr1_end", radr1, 8);
    chk("fill1_end", fill1, 0);
    chk("valid1_end", valid1, 0);
    chk("radr8_end", radr8, 8);
    chk("fill8_end", fill8, 0);
    chk("radr4_end", radr4, 8);
    chk("fill4_end", fill4, 0);
    // partial lane waits for its tail byte
    reset;
    wr(16'h0000, 8'hE0, A);
    chk("part_fill4", fill4, 3);
    repeat (4) step;
    chk("part_novalid4", valid4, 0);
    wr(16'h0000, 8'h10, 64'h0000_0033_0000_0000);
    chk("tail_fill4", fill4, 4);
    step;
    step;
    chk("tail_valid4", valid4, 1);
    chk("tail_data4", data4, 32'h33221100);
    // backpressure holds data, then drains back to back
    reset;
    out_ready = 1'b0;
    wr(16'h0000, 8'hFF, A);
    wr(16'h0008, 8'hFF, B);
    step;
    for (int k = 0; k < 10; k++) begin
      chk("hold_data8", data8, 64'h7766554433221100);
      chk("hold_valid8", valid8, 1);
      step;
    end
    chk("hold_fill8", fill8, 16);
    chk("hold_radr8", radr8, 0);
    out_ready = 1'b1;
    step;
    chk("drain_data8", data8, 64'hFFEEDDCCBBAA9988);
    chk("drain_valid8", valid8, 1);
    chk("drain_radr8", radr8, 8);
    step;
    chk("drain_empty8", valid8, 0);
    chk("drain_radr8b", radr8, 16);
    chk("drain_fill8", fill8, 0);
    // 4112 bytes through a 4 KiB buffer, then overfill
    reset;
    out_ready = 1'b1;
    for (int i = 0; i < 514; i++) begin
      rx_wadr = 16'(i * 8);
      rx_wenb = 8'hFF;
      rx_wdat = {2{32'(i)}};
      step;
    end
    rx_wenb = '0;
    repeat (6) step;
    chk("wrap_radr8", radr8, 16'h0010);
    chk("wrap_ovf8", ovf8, 0);
    chk("wrap_fill8", fill8, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 512; i++) begin
      rx_wadr = 16'(i * 8);
      rx_wenb = 8'hFF;
      rx_wdat = {2{32'(i)}};
      step;
    end
    rx_wenb = '0;
    step;
    chk("full_fill8", fill8, 4096);
    chk("full_noovf8", ovf8, 0);
    wr(16'h0000, 8'h80, 64'h0);
    chk("ovf_set8", ovf8, 1);
    chk("ovf_fill8", fill8, 4097);
    repeat (3) step;
    chk("ovf_sticky8", ovf8, 1);
    // USER_CLR with enable already high still passes through the pending state
    user_clr = 1'b1;
    rx_clr_enb = 1'b1;
    step;
    chk("pend_noreq", clr_req8, 0);
    user_clr = 1'b0;
    step;
    chk("exec_req", clr_req8, 1);
    rx_clr_enb = 1'b0;
    rx_wenb = 8'hFF;
    step;
    rx_wenb = '0;
    chk("clr_req_drop", clr_req8, 0);
    chk("clr_ovf8", ovf8, 0);
    chk("clr_fill8", fill8, 0);
    chk("clr_valid8", valid8, 0);
    chk("clr_radr8", radr8, 0);
    // pending clear lets data flow until SiTCP enables it
    out_ready = 1'b1;
    user_clr = 1'b1;
    step;
    user_clr = 1'b0;
    wr(16'h0000, 8'hFF, A);
    chk("pend_req0", clr_req8, 0);
    step;
    step;
    chk("pend_valid8", valid8, 1);
    chk("pend_data8", data8, 64'h7766554433221100);
    chk("pend_req1", clr_req8, 0);
    step;
    chk("pend_radr8", radr8, 8);
    out_ready = 1'b0;
    wr(16'h0008, 8'hFF, B);
    step;
    step;
    chk("pend_valid8b", valid8, 1);
    chk("pend_fill8", fill8, 8);
    rx_clr_enb = 1'b1;
    step;
    chk("late_req", clr_req8, 1);
    rx_clr_enb = 1'b0;
    step;
    chk("late_req_drop", clr_req8, 0);
    chk("late_radr8", radr8, 0);
    chk("late_fill8", fill8, 0);
    chk("late_valid8", valid8, 0);
    // asynchronous reset mid-stream
    out_ready = 1'b1;
    wr(16'h0000, 8'hFF, A);
    repeat (3) step;
    chk("mid_radr8", radr8, 8);
    out_ready = 1'b0;
    wr(16'h0008, 8'hFF, B);
    step;
    step;
    chk("mid_valid8", valid8, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid8", valid8, 0);
    chk("arst_data8", data8, 0);
    chk("arst_radr8", radr8, 0);
    chk("arst_fill8", fill8, 0);
    chk("arst_valid1", valid1, 0);
    rstn = 1'b1;
    repeat (3) step;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sitcpxg_rx_buffer.md
SITCPXG_RX_BUFFER -- requirements
Module: sitcpxg_rx_buffer

Interface
REQ-001 SHALL have parameter LANE_BYTES, default 8: user output lane width in bytes; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter ADDR_BITS, default 13: buffer size is 2^ADDR_BITS bytes; legal range 12..16.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, as listed in REQ-004 and REQ-005.
REQ-004 XGMII_CLOCK  in  1  156.25 MHz clock; all logic on rising edge.
REQ-005 RSTn  in  1  asynchronous active-low reset.
REQ-006 RX_WADR  in  16  SiTCP receive write byte address; bits [2:0] ignored.
REQ-007 RX_WENB  in  8  SiTCP byte write enables, big endian (bit7 = lowest address).
REQ-008 RX_WDAT  in  64  SiTCP write data, big endian ([63:56] = lowest address).
REQ-009 RX_CLR_ENB  in  1  SiTCP clear-enable.
REQ-010 RX_CLR_REQ  out  1  clear request to SiTCP.
REQ-011 RX_RADR  out  16  released read byte address to SiTCP; bits above ADDR_BITS-1 are 0.
REQ-012 RX_SIZE  out  16  constant 2^ADDR_BITS-16.
REQ-013 USER_CLR  in  1  user clear request pulse.
REQ-014 OUT_DATA  out  8*LANE_BYTES  lane data, little endian ([7:0] = lowest address).
REQ-015 OUT_VALID / OUT_READY  out / in  1 / 1  valid-ready handshake; a beat transfers when both are 1.
REQ-016 FILL  out  ADDR_BITS+1  bytes written and not yet released.
REQ-017 OVERFLOW  out  1  sticky flag: write would exceed capacity.

Function
REQ-018 SHALL hold 2^(ADDR_BITS-3) x 64-bit words with byte write enables; a write at RX_WADR[ADDR_BITS-1:3] writes byte i when RX_WENB[i]=1.
REQ-019 SHALL add popcount(RX_WENB) to the write byte count each cycle; writes are contiguous in address order.
REQ-020 SHALL issue a read when unissued bytes >= LANE_BYTES and the output queue has room; it SHALL NOT issue a read for a partial lane (tail bytes wait for further data).
REQ-021 Latency: the first beat's OUT_VALID SHALL rise 2 cycles after the write that completes the lane (1-cycle RAM read + output register).
REQ-022 Throughput: 1 beat per cycle under continuous OUT_READY=1; a 2-entry output queue SHALL absorb read pipeline slip.
REQ-023 While OUT_VALID=1 and OUT_READY=0, OUT_DATA SHALL remain stable.
REQ-024 Lane k of a word SHALL carry bytes at addresses word*8 + k*LANE_BYTES + j in order j = 0..LANE_BYTES-1, reversed into little-endian order on OUT_DATA.
REQ-025 On each transfer, RX_RADR SHALL advance by LANE_BYTES modulo 2^ADDR_BITS, and FILL SHALL decrease by LANE_BYTES.
REQ-026 A write and a transfer in the same cycle: FILL SHALL change by popcount - LANE_BYTES.
REQ-027 If FILL + popcount > 2^ADDR_BITS, OVERFLOW SHALL set and stay set until reset or clear; the write is still performed.
REQ-028 Clear FSM states: RUN, CLR_PEND, CLR_EXEC.
REQ-029 Clear transitions: RUN->CLR_PEND on USER_CLR=1; CLR_PEND->CLR_EXEC when RX_CLR_ENB=1; CLR_EXEC->RUN after 1 cycle.
REQ-030 USER_CLR=1 with RX_CLR_ENB=1 in RUN SHALL still pass through CLR_PEND; USER_CLR in CLR_PEND or CLR_EXEC SHALL be ignored.
REQ-031 In CLR_EXEC, RX_CLR_REQ=1 for exactly 1 cycle.
REQ-032 In CLR_EXEC, the following SHALL be zeroed on the next edge: write count, read count, RX_RADR, FILL, OVERFLOW, output queue (OUT_VALID=0).
REQ-033 In CLR_EXEC, RX_WENB is ignored.
REQ-034 In CLR_PEND, normal data flow SHALL continue.

Reset
REQ-035 RSTn=0 SHALL asynchronously force: OUT_VALID=0, OUT_DATA=0, RX_CLR_REQ=0, RX_RADR=0, FILL=0, OVERFLOW=0, state RUN.
REQ-036 Reset mid-transfer SHALL discard all queued beats; RAM contents are don't-care.
REQ-037 Reset deassertion SHALL be synchronised inside the block; the first write is accepted on the 2nd edge after RSTn rises.

Verification
REQ-038 LANE_BYTES=8: write WADR=0, WENB=FF, WDAT=0x0011223344556677 -> 2 cycles later OUT_VALID=1, OUT_DATA=0x7766554433221100; after transfer RX_RADR=8, FILL=0.
REQ-039 LANE_BYTES=1, same write, OUT_READY=1 -> 8 consecutive beats 0x00..0x77; RX_RADR steps 1..8.
REQ-040 LANE_BYTES=4: write WENB=E0 -> FILL=3, OUT_VALID stays 0; then WADR=0, WENB=10, byte3=0x33 -> beat 0x33221100.
REQ-041 OUT_READY=0 for 10 cycles with 16 bytes written -> OUT_DATA stable, FILL=16, RX_RADR=0; release -> 2 beats on consecutive cycles.
REQ-042 ADDR_BITS=12, stream 4112 bytes with continuous reads -> RX_RADR=0x0010, OVERFLOW=0; then 4097 bytes with no reads -> OVERFLOW=1.
REQ-043 USER_CLR pulse with RX_CLR_ENB=0 -> RX_CLR_REQ stays 0 and data flows; raise RX_CLR_ENB -> RX_CLR_REQ=1 for 1 cycle, then RX_RADR=0, FILL=0, OUT_VALID=0; RSTn pulse mid-stream -> same zeros immediately.
